// File: rtl/mole_round_controller.sv
// mole_round_controller: sequences one whack-a-mole round on a 16-hole grid.
// Spawns a single mole at a pseudo-random hole, times its up-window, and
// detects hits on button rising edges. It keeps the score and miss count,
// shortens the up-window after each hit, and ends the game after MAX_MISSES misses.
// Optional build macro: WRONG_PRESS_PENALTY_EN -- when defined, pressing any
// hole other than the mole's hole while the mole is up counts as a miss.
module mole_round_controller #(
    parameter int unsigned UP_CYCLES     = 14000000,
    parameter int unsigned MIN_UP_CYCLES = 3500000,
    parameter int unsigned STEP_CYCLES   = 700000,
    parameter int unsigned GAP_CYCLES    = 4200000,
    parameter int unsigned MAX_MISSES    = 3,
    parameter int unsigned SCORE_W       = 8
) (
    input  logic               clock_14MHz_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [15:0]        buttons_i,
    input  logic [3:0]         rand_i,
    output logic [15:0]        mole_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [3:0]         misses_o,
    output logic               playing_o,
    output logic               game_over_o,
    output logic               hit_o,
    output logic               miss_o
);

    // One timer serves both the up-window and the gap, so it is sized for the longer one.
    localparam int unsigned MAX_CYC = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0]      UP_LEN_INIT = TW'(UP_CYCLES);
    localparam logic [TW-1:0]      MIN_LEN     = TW'(MIN_UP_CYCLES);
    localparam logic [TW-1:0]      STEP_LEN    = TW'(STEP_CYCLES);
    localparam logic [TW-1:0]      GAP_LAST    = TW'(GAP_CYCLES - 1);
    localparam logic [3:0]         MISS_LIMIT  = 4'(MAX_MISSES);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_W{1'b1}};
    // A step is applied only when it cannot take the window below its floor.
    localparam logic [32:0]        SPEEDUP_MIN = 33'(MIN_UP_CYCLES) + 33'(STEP_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_UP    = 3'd2,
        ST_HIT   = 3'd3,
        ST_MISS  = 3'd4,
        ST_GAP   = 3'd5,
        ST_OVER  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic               start_q;
    logic [15:0]        btn_q;
    logic [15:0]        mole_q, mole_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         misses_q, misses_d;
    logic [TW-1:0]      up_len_q, up_len_d;
    logic [3:0]         last_loc_q, last_loc_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               playing_q, playing_d;
    logic               over_q, over_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;

    logic               start_rise_s;
    logic [15:0]        press_s;
    logic [3:0]         loc_s;
    logic               hit_now_s;
    logic               wrong_s;
    logic               timeout_s;

    assign start_rise_s = start_i & ~start_q;
    assign press_s      = buttons_i & ~btn_q;
    // Avoid showing the mole in the same hole twice in a row.
    assign loc_s        = (rand_i == last_loc_q) ? (rand_i + 4'd1) : rand_i;
    // mole_q is one-hot during UP, so masking with it selects press[loc].
    assign hit_now_s    = |(press_s & mole_q);
    assign timeout_s    = (timer_q == (up_len_q - TW'(1)));
`ifdef WRONG_PRESS_PENALTY_EN
    assign wrong_s      = |(press_s & ~mole_q);
`else
    assign wrong_s      = 1'b0;
`endif

    // Next-state, counters and registered-output values for the round FSM.
    always_comb begin
        state_d    = state_q;
        mole_d     = mole_q;
        score_d    = score_q;
        misses_d   = misses_q;
        up_len_d   = up_len_q;
        last_loc_d = last_loc_q;
        timer_d    = timer_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise_s) begin
                    state_d  = ST_SPAWN;
                    score_d  = '0;
                    misses_d = 4'd0;
                    up_len_d = UP_LEN_INIT;
                end else begin
                    state_d  = state_q;
                end
            end
            ST_SPAWN: begin
                last_loc_d = loc_s;
                mole_d     = 16'd1 << loc_s;
                timer_d    = '0;
                state_d    = ST_UP;
            end
            ST_UP: begin
                if (hit_now_s) begin
                    // A correct press beats a timeout or wrong press in the same cycle.
                    state_d = ST_HIT;
                    mole_d  = 16'd0;
                    hit_d   = 1'b1;
                    timer_d = '0;
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + {{(SCORE_W-1){1'b0}}, 1'b1};
                    end else begin
                        score_d = score_q;
                    end
                    if (33'(up_len_q) >= SPEEDUP_MIN) begin
                        up_len_d = up_len_q - STEP_LEN;
                    end else begin
                        up_len_d = MIN_LEN;
                    end
                end else if (timeout_s || wrong_s) begin
                    state_d  = ST_MISS;
                    mole_d   = 16'd0;
                    miss_d   = 1'b1;
                    misses_d = misses_q + 4'd1;
                    timer_d  = '0;
                end else begin
                    timer_d  = timer_q + TW'(1);
                end
            end
            ST_HIT: begin
                state_d = ST_GAP;
            end
            ST_MISS: begin
                if (misses_q == MISS_LIMIT) begin
                    state_d = ST_OVER;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d = ST_SPAWN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                mole_d  = 16'd0;
            end
        endcase

        playing_d = (state_d == ST_SPAWN) || (state_d == ST_UP) || (state_d == ST_HIT) ||
                    (state_d == ST_MISS)  || (state_d == ST_GAP);
        over_d    = (state_d == ST_OVER);
    end

    // State, counters, edge-detect history and registered outputs.
    always_ff @(posedge clock_14MHz_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            btn_q      <= 16'd0;
            mole_q     <= 16'd0;
            score_q    <= '0;
            misses_q   <= 4'd0;
            up_len_q   <= UP_LEN_INIT;
            last_loc_q <= 4'd0;
            timer_q    <= '0;
            playing_q  <= 1'b0;
            over_q     <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_i;
            btn_q      <= buttons_i;
            mole_q     <= mole_d;
            score_q    <= score_d;
            misses_q   <= misses_d;
            up_len_q   <= up_len_d;
            last_loc_q <= last_loc_d;
            timer_q    <= timer_d;
            playing_q  <= playing_d;
            over_q     <= over_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    assign mole_o      = mole_q;
    assign score_o     = score_q;
    assign misses_o    = misses_q;
    assign playing_o   = playing_q;
    assign game_over_o = over_q;
    assign hit_o       = hit_q;
    assign miss_o      = miss_q;

endmodule
